seq_add_sub: RTL and testbench

//  Multi-cycle parametrised adder/subtractor for the calculator datapath. It

---
 rtl/seq_add_sub.sv | 116 +++++++++++
 tb/tb_seq_add_sub.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// Multi-cycle chunked adder/subtractor with a registered carry chain and start/busy/done handshake.
// Optional build macro SEQ_ADD_SUB_SAT_EN enables signed saturation of the result on overflow.
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("seq_add_sub: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next, final_sum;
  logic [CHUNK:0]   chunk_add;
  logic [CW-1:0]    cnt;
  logic             carry, a_msb, b_msb;
  logic             accept, last, raw_ovf;

  assign busy   = (state == RUN);
  assign accept = start && !busy;
  assign last   = (state == RUN) && (cnt == LAST);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One chunk per cycle; the new chunk enters at the top so the LSB chunk ends up at the bottom.
  always_comb begin
    chunk_add = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + (CHUNK+1)'(carry);
    res_next  = (res_sh >> CHUNK) | (WIDTH'(chunk_add[CHUNK-1:0]) << (WIDTH - CHUNK));
    raw_ovf   = (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
`ifdef SEQ_ADD_SUB_SAT_EN
    if (raw_ovf) final_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else         final_sum = res_next;
`else
    final_sum = res_next;
`endif
  end

  // NOTE: working shift registers are reset as well, keeping the block fully deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= sub ? ~b : b;
      carry  <= sub;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (busy) begin
      a_sh   <= a_sh >> CHUNK;
      b_sh   <= b_sh >> CHUNK;
      res_sh <= res_next;
      carry  <= chunk_add[CHUNK];
      cnt    <= cnt + 1'b1;
    end
  end

  // Visible results move only on the last chunk edge; they stay put while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        sum       <= final_sum;
        carry_out <= chunk_add[CHUNK];
        overflow  <= raw_ovf;
        zero      <= (final_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub (WIDTH=16, CHUNK=4): vector table plus handshake/reset sequences.
// Expected sums follow SEQ_ADD_SUB_SAT_EN when the build defines it.
module tb_seq_add_sub;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n, start, sub;
  logic [WIDTH-1:0] a, b, sum;
  logic             busy, done, carry_out, overflow, zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[9];

  seq_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic is);
    a = ia; b = ib; sub = is; start = 1'b1;
  endtask

  task automatic release_start();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic is);
    @(negedge clk);
    drive(ia, ib, is);
    release_start();
  endtask

  // Returns number of falling edges until done is seen (bounded) and whether sum held meanwhile.
  task automatic wait_done(output int n, output logic held);
    logic [15:0] s0;
    s0 = sum; n = 0; held = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (sum !== s0) held = 1'b0;
    end
  endtask

  initial begin
    int          n;
    logic        held;
    logic        saw_done;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h0003, 16'h0004, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h00A5, 16'h005A, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
`ifdef SEQ_ADD_SUB_SAT_EN
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
`else
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
`endif

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_flags", {carry_out, overflow, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(n, held);
      check($sformatf("v%0d_latency", i), n - 1, NCHUNK);
      check($sformatf("v%0d_hold", i), held, 1);
      check($sformatf("v%0d_busy_in_done", i), busy, 0);
      check($sformatf("v%0d_sum", i), sum, vecs[i].s);
      check($sformatf("v%0d_carry", i), carry_out, vecs[i].c);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].v);
      check($sformatf("v%0d_zero", i), zero, vecs[i].z);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Start while busy must be ignored; start in the done cycle must be accepted.
    issue(16'h0001, 16'h0001, 1'b0);
    @(posedge clk);
    #1 drive(16'h0005, 16'h0005, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, held);
    check("busy_ignore_latency", n, 3);
    check("busy_ignore_sum", sum, 16'h0002);
    drive(16'h0003, 16'h0004, 1'b1);
    release_start();
    wait_done(n, held);
    check("b2b_latency", n - 1, NCHUNK);
    check("b2b_sum", sum, 16'hFFFF);
    check("b2b_carry", carry_out, 0);

    // Reset mid-operation: outputs clear at once, no done pulse, fresh op works.
    issue(16'h1234, 16'h0FFF, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_flags", {done, carry_out, overflow, zero}, 0);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    issue(16'h0001, 16'h0002, 1'b0);
    wait_done(n, held);
    check("post_rst_latency", n - 1, NCHUNK);
    check("post_rst_sum", sum, 16'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
